// File: rtl/voting_pkg.sv
// rtl/voting_pkg.sv - shared types and constants for the three-candidate ballot counter
package voting_pkg;

  typedef enum logic {
    VOTING = 1'b0,
    CLOSED = 1'b1
  } state_t;

  localparam int NUM_CAND      = 3;
  localparam int DEFAULT_CNT_W = 32;

endpackage

// File: rtl/vote_counter.sv
// rtl/vote_counter.sv - per-candidate press edge detector and saturating tally
module vote_counter
  import voting_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  input  logic             en,
  output logic             rise,
  output logic [CNT_W-1:0] count
);

  logic btn_q;

  assign rise = btn & ~btn_q;

  // History keeps tracking after close so a held button cannot fake a press later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q <= 1'b0;
      count <= '0;
    end else begin
      btn_q <= btn;
      if (en && rise && (count != '1)) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/voting_machine.sv
// rtl/voting_machine.sv - ballot FSM, invalid-ballot filter and registered result outputs
module voting_machine
  import voting_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_candidate_1,
  input  logic             i_candidate_2,
  input  logic             i_candidate_3,
  input  logic             i_voting_over,
  output logic [CNT_W-1:0] o_count1,
  output logic [CNT_W-1:0] o_count2,
  output logic [CNT_W-1:0] o_count3
);

  state_t                    state_q;
  state_t                    state_d;
  logic [NUM_CAND-1:0]       buttons;
  logic [NUM_CAND-1:0]       rises;
  logic                      count_en;
  logic [CNT_W-1:0]          tally [NUM_CAND];

  assign buttons = {i_candidate_3, i_candidate_2, i_candidate_1};

  // Only a single rising button is a valid ballot; the closing edge wins over any press.
  assign count_en = (state_q == VOTING) && !i_voting_over && $onehot(rises);

  for (genvar i = 0; i < NUM_CAND; i++) begin : g_cand
    vote_counter #(.CNT_W(CNT_W)) u_counter (
      .clk   (clk),
      .rst   (rst),
      .btn   (buttons[i]),
      .en    (count_en),
      .rise  (rises[i]),
      .count (tally[i])
    );
  end

  always_comb begin
    state_d = state_q;
    if (state_q == VOTING && i_voting_over) begin
      state_d = CLOSED;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= VOTING;
    end else begin
      state_q <= state_d;
    end
  end

  // Results load on the closing edge; tallies are already frozen then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_count1 <= '0;
      o_count2 <= '0;
      o_count3 <= '0;
    end else if (state_d == CLOSED) begin
      o_count1 <= tally[0];
      o_count2 <= tally[1];
      o_count3 <= tally[2];
    end else begin
      o_count1 <= '0;
      o_count2 <= '0;
      o_count3 <= '0;
    end
  end

endmodule

// File: tb/tb_voting_machine.sv
// tb/tb_voting_machine.sv - self-checking bench for voting_machine (32-bit and 2-bit counters)
module tb_voting_machine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        c1 = 1'b0, c2 = 1'b0, c3 = 1'b0, vo = 1'b0;
  logic [31:0] o1, o2, o3;
  logic [1:0]  s1, s2, s3;

  int tests  = 0;
  int failed = 0;

  // Reference state: plain vote totals, last seen buttons, polls-closed flag.
  int m_cnt [3];
  bit m_prev [3];
  bit m_closed;

  typedef struct {
    logic c1, c2, c3, vo;
    int   e1, e2, e3;
  } vec_t;

  vec_t tbl [18];

  always #5 clk = ~clk;

  voting_machine dut (
    .clk(clk), .rst(rst),
    .i_candidate_1(c1), .i_candidate_2(c2), .i_candidate_3(c3),
    .i_voting_over(vo),
    .o_count1(o1), .o_count2(o2), .o_count3(o3)
  );

  voting_machine #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .i_candidate_1(c1), .i_candidate_2(c2), .i_candidate_3(c3),
    .i_voting_over(vo),
    .o_count1(s1), .o_count2(s2), .o_count3(s3)
  );

  function automatic int sat2(int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect3(input string name, input int e1, input int e2, input int e3);
    chk({name, " o_count1"}, o1, e1);
    chk({name, " o_count2"}, o2, e2);
    chk({name, " o_count3"}, o3, e3);
    chk({name, " sat o_count1"}, s1, sat2(e1));
    chk({name, " sat o_count2"}, s2, sat2(e2));
    chk({name, " sat o_count3"}, s3, sat2(e3));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i]  = 0;
      m_prev[i] = 1'b0;
    end
    m_closed = 1'b0;
  endtask

  task automatic model_edge();
    bit b [3];
    int nrise;
    int who;
    b[0] = c1; b[1] = c2; b[2] = c3;
    nrise = 0;
    who   = 0;
    for (int i = 0; i < 3; i++) begin
      if (b[i] && !m_prev[i]) begin
        nrise++;
        who = i;
      end
    end
    if (!m_closed && !vo && nrise == 1) m_cnt[who]++;
    if (vo) m_closed = 1'b1;
    for (int i = 0; i < 3; i++) m_prev[i] = b[i];
  endtask

  task automatic model_check(input string name);
    if (m_closed) expect3(name, m_cnt[0], m_cnt[1], m_cnt[2]);
    else          expect3(name, 0, 0, 0);
  endtask

  task automatic step(input logic a, input logic b, input logic c, input logic v);
    c1 = a; c2 = b; c3 = c; vo = v;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset(input string name);
    c1 = 0; c2 = 0; c3 = 0; vo = 0;
    rst = 1'b1;
    #1;
    expect3({name, " async"}, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    expect3({name, " released"}, 0, 0, 0);
  endtask

  initial begin
    // Spec sequence c1,c2,c1,c3,c2,c2,c1,c3 as one-cycle pulses separated by idle cycles.
    automatic int seq [8] = '{1, 2, 1, 3, 2, 2, 1, 3};
    for (int i = 0; i < 8; i++) begin
      tbl[2*i]   = '{seq[i] == 1, seq[i] == 2, seq[i] == 3, 1'b0, 0, 0, 0};
      tbl[2*i+1] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    end
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 3, 3, 2};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 3, 3, 2};

    model_reset();
    do_reset("reset");

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].c1, tbl[i].c2, tbl[i].c3, tbl[i].vo);
      expect3($sformatf("table row %0d", i), tbl[i].e1, tbl[i].e2, tbl[i].e3);
    end

    // Held button counts once.
    do_reset("reset before hold");
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    expect3("held c1", 1, 0, 0);

    // Simultaneous press is an invalid ballot.
    do_reset("reset before invalid");
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    expect3("invalid before close", 0, 0, 0);
    step(0, 0, 0, 1);
    expect3("invalid ballot", 0, 0, 1);

    // Close freezes tallies; press on the closing edge and later presses are ignored.
    do_reset("reset before freeze");
    step(1, 0, 0, 0); step(0, 0, 0, 0);
    step(1, 0, 0, 0); step(0, 0, 0, 0);
    step(1, 0, 0, 1);
    expect3("press on close edge", 2, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
    end
    step(0, 0, 0, 0);
    expect3("frozen after close", 2, 0, 0);
    do_reset("reset mid closed");

    // Saturation: four presses reach 4 on 32-bit, stick at 3 on 2-bit.
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
    end
    step(0, 0, 0, 1);
    expect3("saturation", 4, 0, 0);

    // Randomised rounds against the reference model.
    for (int r = 0; r < 4; r++) begin
      do_reset($sformatf("random reset %0d", r));
      for (int n = 0; n < 400; n++) begin
        step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 2) == 0,
             ($urandom_range(0, 299) == 0) || (n == 370));
        model_check($sformatf("random r%0d n%0d", r, n));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
